// File: rtl/e203_exu_wbck_sched_pkg.sv
// Shared widths and FSM encodings for the EXU writeback scheduler.
// Mirrors the E203 defines so the bench can reuse them.
package e203_exu_wbck_sched_pkg;

  localparam int E203_XLEN        = 32;
  localparam int E203_RFIDX_WIDTH = 5;

  typedef enum logic {
    E203_WBSCHED_NORM  = 1'b0,
    E203_WBSCHED_BOOST = 1'b1
  } wbsched_state_e;

  localparam logic SRC_ALU   = 1'b0;
  localparam logic SRC_LONGP = 1'b1;

endpackage

// File: rtl/e203_exu_wbck_ostage.sv
// One-entry valid/ready register slice; load and drain may share a cycle.
// out_vld is purely registered, so out_rdy never reaches it combinationally.
module e203_exu_wbck_ostage #(
  parameter int W = 38
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_load,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat
);

  logic         vld_q, vld_d;
  logic [W-1:0] dat_q, dat_d;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (out_rdy) vld_d = 1'b0;
    if (in_load) begin
      vld_d = 1'b1;
      dat_d = in_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign out_vld = vld_q;
  assign out_dat = dat_q;

endmodule

// File: rtl/e203_exu_wbck_sched.sv
// Regfile write-port scheduler: ALU priority with a starvation boost for
// the OITF-ordered long pipe, feeding a one-entry output stage.
module e203_exu_wbck_sched
  import e203_exu_wbck_sched_pkg::*;
#(
  parameter int XLEN       = E203_XLEN,
  parameter int RFIDX_W    = E203_RFIDX_WIDTH,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alu_wbck_i_valid,
  output logic               alu_wbck_i_ready,
  input  logic [XLEN-1:0]    alu_wbck_i_wdat,
  input  logic [RFIDX_W-1:0] alu_wbck_i_rdidx,
  input  logic               longp_wbck_i_valid,
  output logic               longp_wbck_i_ready,
  input  logic [XLEN-1:0]    longp_wbck_i_wdat,
  input  logic [RFIDX_W-1:0] longp_wbck_i_rdidx,
  output logic               rf_wbck_o_valid,
  input  logic               rf_wbck_o_ready,
  output logic [XLEN-1:0]    rf_wbck_o_wdat,
  output logic [RFIDX_W-1:0] rf_wbck_o_rdidx,
  output logic               rf_wbck_o_src,
  output logic               starve_boost
);

  localparam int              EW        = 1 + RFIDX_W + XLEN;
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;
  localparam logic [CNT_W-1:0] STARVE_TH = CNT_W'(STARVE_MAX);

  wbsched_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             out_vld, stage_free;
  logic             gnt_alu, gnt_lp, acc_alu, acc_lp, load, lp_starved;
  logic [EW-1:0]    ld_ent, out_ent;

  assign stage_free = ~out_vld | rf_wbck_o_ready;

  always_comb begin
    gnt_alu = 1'b0;
    gnt_lp  = 1'b0;
    if (state_q == E203_WBSCHED_BOOST) begin
      gnt_lp  = longp_wbck_i_valid;
      gnt_alu = alu_wbck_i_valid & ~longp_wbck_i_valid;
    end else begin
      gnt_alu = alu_wbck_i_valid;
      gnt_lp  = longp_wbck_i_valid & ~alu_wbck_i_valid;
    end
  end

  assign alu_wbck_i_ready   = ~rst & stage_free & gnt_alu;
  assign longp_wbck_i_ready = ~rst & stage_free & gnt_lp;
  assign acc_alu = alu_wbck_i_valid & alu_wbck_i_ready;
  assign acc_lp  = longp_wbck_i_valid & longp_wbck_i_ready;

  // x0 writes complete the handshake but never occupy the output stage
  assign load = (acc_alu & (|alu_wbck_i_rdidx)) | (acc_lp & (|longp_wbck_i_rdidx));
  assign ld_ent = acc_lp ? {SRC_LONGP, longp_wbck_i_rdidx, longp_wbck_i_wdat}
                         : {SRC_ALU,   alu_wbck_i_rdidx,   alu_wbck_i_wdat};

  assign lp_starved = longp_wbck_i_valid & ~acc_lp;
  assign cnt_inc    = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    cnt_d   = lp_starved ? cnt_inc : '0;
    state_d = state_q;
    case (state_q)
      E203_WBSCHED_NORM:  if (lp_starved && cnt_inc >= STARVE_TH) state_d = E203_WBSCHED_BOOST;
      E203_WBSCHED_BOOST: if (acc_lp) state_d = E203_WBSCHED_NORM;
      default:            state_d = E203_WBSCHED_NORM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= E203_WBSCHED_NORM;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  e203_exu_wbck_ostage #(.W(EW)) u_ostage (
    .clk     (clk),
    .rst     (rst),
    .in_load (load),
    .in_dat  (ld_ent),
    .out_vld (out_vld),
    .out_rdy (rf_wbck_o_ready),
    .out_dat (out_ent)
  );

  assign rf_wbck_o_valid = out_vld;
  assign {rf_wbck_o_src, rf_wbck_o_rdidx, rf_wbck_o_wdat} = out_ent;
  assign starve_boost = (state_q == E203_WBSCHED_BOOST);

endmodule

// File: tb/tb_e203_exu_wbck_sched.sv
// Table-driven bench for the writeback scheduler with a write scoreboard;
// a second instance with STARVE_MAX=7 tracks the saturation corner.
module tb_e203_exu_wbck_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        av, lv, rr;
  logic [4:0]  ai, li;
  logic [31:0] ad, ld;
  logic        ar, lr, rv, rsrc, boost;
  logic [4:0]  ridx;
  logic [31:0] rdat;
  logic        ar7, lr7, rv7, rsrc7, boost7;
  logic [4:0]  ridx7;
  logic [31:0] rdat7;

  always #5 clk = ~clk;

  e203_exu_wbck_sched dut (
    .clk(clk), .rst(rst),
    .alu_wbck_i_valid(av), .alu_wbck_i_ready(ar), .alu_wbck_i_wdat(ad), .alu_wbck_i_rdidx(ai),
    .longp_wbck_i_valid(lv), .longp_wbck_i_ready(lr), .longp_wbck_i_wdat(ld), .longp_wbck_i_rdidx(li),
    .rf_wbck_o_valid(rv), .rf_wbck_o_ready(rr), .rf_wbck_o_wdat(rdat), .rf_wbck_o_rdidx(ridx),
    .rf_wbck_o_src(rsrc), .starve_boost(boost)
  );

  e203_exu_wbck_sched #(.STARVE_MAX(7)) dut7 (
    .clk(clk), .rst(rst),
    .alu_wbck_i_valid(av), .alu_wbck_i_ready(ar7), .alu_wbck_i_wdat(ad), .alu_wbck_i_rdidx(ai),
    .longp_wbck_i_valid(lv), .longp_wbck_i_ready(lr7), .longp_wbck_i_wdat(ld), .longp_wbck_i_rdidx(li),
    .rf_wbck_o_valid(rv7), .rf_wbck_o_ready(rr), .rf_wbck_o_wdat(rdat7), .rf_wbck_o_rdidx(ridx7),
    .rf_wbck_o_src(rsrc7), .starve_boost(boost7)
  );

  typedef struct {
    bit          rst, av;
    logic [4:0]  ai;
    logic [31:0] ad;
    bit          lv;
    logic [4:0]  li;
    logic [31:0] ld;
    bit          rr, ear, elr, eb, eb7;
  } vec_t;

  vec_t        vq[$];
  logic [37:0] sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic v(input bit r, a, input logic [4:0] x, input logic [31:0] xd,
                   input bit l, input logic [4:0] y, input logic [31:0] yd,
                   input bit rdy, ea, el, b, b7);
    vec_t t;
    t.rst = r; t.av = a; t.ai = x; t.ad = xd; t.lv = l; t.li = y; t.ld = yd;
    t.rr = rdy; t.ear = ea; t.elr = el; t.eb = b; t.eb7 = b7;
    vq.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; av = 0; lv = 0; rr = 0; ai = 0; li = 0; ad = 0; ld = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #3;
    chk("reset rf_valid", rv, 0);
    chk("reset wdat", rdat, 0);
    chk("reset rdidx", ridx, 0);
    chk("reset src", rsrc, 0);
    chk("reset boost", boost, 0);
    chk("reset boost7", boost7, 0);
    @(posedge clk); #1;

    // ALU-only back-to-back
    v(0, 1, 5, 32'h1234, 0, 0, 0, 1, 1, 0, 0, 0);
    v(0, 1, 6, 32'h55,   0, 0, 0, 1, 1, 0, 0, 0);
    v(0, 1, 7, 32'h66,   0, 0, 0, 1, 1, 0, 0, 0);
    v(0, 0, 0, 0,        0, 0, 0, 1, 0, 0, 0, 0);
    // both valid: ALU wins 4 times, then one boosted long-pipe grant
    for (int i = 0; i < 4; i++) v(0, 1, 1, 32'hA1 + i, 1, 2, 32'hB1, 1, 1, 0, 0, 0);
    v(0, 1, 1, 32'hA5, 1, 2, 32'hB1, 1, 0, 1, 1, 0);
    v(0, 1, 1, 32'hA6, 1, 2, 32'hB2, 1, 1, 0, 0, 0);
    v(0, 1, 1, 32'hA7, 1, 2, 32'hB2, 1, 1, 0, 0, 0);
    v(0, 1, 1, 32'hA8, 1, 2, 32'hB2, 1, 1, 0, 0, 1);
    // stage blocked with both valid, then drain+load in one cycle
    v(0, 1, 1, 32'hA9, 1, 2, 32'hB2, 0, 0, 0, 0, 0);
    v(0, 1, 1, 32'hA9, 1, 2, 32'hB2, 0, 0, 0, 1, 0);
    v(0, 1, 1, 32'hA9, 1, 2, 32'hB2, 1, 0, 1, 1, 0);
    // long-pipe x0 write: handshake without a regfile write
    v(0, 0, 0, 0, 1, 0, 32'hFFFF_FFFF, 1, 0, 1, 0, 0);
    v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    // reach BOOST with a buffered entry, then reset over it
    for (int i = 0; i < 4; i++) v(0, 1, 3, 32'hC1 + i, 1, 4, 32'hD1, 1, 1, 0, 0, 0);
    v(1, 1, 3, 32'hC5, 1, 4, 32'hD1, 0, 0, 0, 1, 0);
    v(1, 1, 3, 32'hC6, 1, 4, 32'hD1, 1, 0, 0, 0, 0);
    v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    // saturation: dut7 boosts after 7 losses and stays boosted while blocked
    for (int i = 0; i < 4; i++) v(0, 1, 8, 32'hE1 + i, 1, 9, 32'hF1, 1, 1, 0, 0, 0);
    v(0, 1, 8, 32'hE5, 1, 9, 32'hF1, 1, 0, 1, 1, 0);
    v(0, 1, 8, 32'hE6, 1, 9, 32'hF1, 1, 1, 0, 0, 0);
    v(0, 1, 8, 32'hE7, 1, 9, 32'hF1, 1, 1, 0, 0, 0);
    v(0, 1, 8, 32'hE8, 1, 9, 32'hF1, 0, 0, 0, 0, 1);
    v(0, 1, 8, 32'hE8, 1, 9, 32'hF1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) v(0, 1, 8, 32'hE8, 1, 9, 32'hF1, 0, 0, 0, 1, 1);
    v(0, 1, 8, 32'hE8, 1, 9, 32'hF1, 1, 0, 1, 1, 1);
    v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    // ALU x0 write
    v(0, 1, 0, 32'hDEAD, 0, 0, 0, 1, 1, 0, 0, 0);
    v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

    for (int k = 0; k < vq.size(); k++) begin
      vec_t t;
      logic [37:0] exp_ent;
      t = vq[k];
      rst = t.rst; av = t.av; ai = t.ai; ad = t.ad;
      lv = t.lv; li = t.li; ld = t.ld; rr = t.rr;
      #3;
      chk($sformatf("row%0d alu_ready", k), ar, t.ear);
      chk($sformatf("row%0d longp_ready", k), lr, t.elr);
      chk($sformatf("row%0d starve_boost", k), boost, t.eb);
      chk($sformatf("row%0d starve_boost7", k), boost7, t.eb7);
      chk($sformatf("row%0d rf_valid", k), rv, sb.size() != 0);
      if (sb.size() != 0) begin
        exp_ent = sb[0];
        chk($sformatf("row%0d rf_entry", k), {rsrc, ridx, rdat}, exp_ent);
        if (t.rr && !t.rst) void'(sb.pop_front());
      end
      if (t.rst) sb.delete();
      else begin
        if (t.ear && t.av && t.ai != 0) sb.push_back({1'b0, t.ai, t.ad});
        if (t.elr && t.lv && t.li != 0) sb.push_back({1'b1, t.li, t.ld});
      end
      @(posedge clk); #1;
    end
    chk("scoreboard drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
